// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and the loader FSM encoding for the panel
// frame path.
//   PANEL_COLS / PANEL_ROWS : panel geometry (powers of two)
//   ADDR_W                  : frame store address width, {row, col}
//   PIX_W                   : packed pixel width, {R, G, B}
package hub75_pkg;

  localparam int PANEL_COLS = 64;
  localparam int PANEL_ROWS = 64;
  localparam int PIX_W      = 24;
  localparam int ADDR_W     = $clog2(PANEL_COLS * PANEL_ROWS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PANEL_COLS * PANEL_ROWS - 1);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    LOAD      = 2'd1,
    SWAP_PEND = 2'd2
  } fl_state_e;

endpackage

// File: rtl/frame_loader_if.sv
// frame_loader_if: RGB888 byte stream into the frame loader.
//   in_valid / in_ready : handshake, a byte moves when both are high
//   in_data             : byte, per pixel order R, G, B
//   in_sof              : marks the R byte of the first pixel of a frame
// master = byte source, slave = frame_loader.
interface frame_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;

  modport master (output in_valid, output in_data, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_data, input in_sof, output in_ready);
endinterface

// File: rtl/frame_loader_packer.sv
// rgb_byte_packer: collects R, G, B bytes into one 24-bit pixel.
//   clk, rst   : clock, synchronous active-high reset
//   accept     : a byte is being consumed this cycle
//   restart    : with accept, drop any partial pixel and take data as R
//   data       : incoming byte
//   byte_idx   : position of the next byte within the pixel (0..2)
//   pix_valid  : combinational, high in the cycle the B byte is consumed
//   pix        : {R, G, B}, valid with pix_valid
module rgb_byte_packer
  import hub75_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             restart,
  input  logic [7:0]       data,
  output logic [1:0]       byte_idx,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix
);

  logic [1:0] idx_q;
  logic [7:0] r_q;
  logic [7:0] g_q;

  assign byte_idx  = idx_q;
  assign pix_valid = accept && !restart && (idx_q == 2'd2);
  assign pix       = {r_q, g_q, data};

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      r_q   <= 8'd0;
      g_q   <= 8'd0;
    end else if (accept && restart) begin
      r_q   <= data;
      idx_q <= 2'd1;
    end else if (accept) begin
      case (idx_q)
        2'd0: begin
          r_q   <= data;
          idx_q <= 2'd1;
        end
        2'd1: begin
          g_q   <= data;
          idx_q <= 2'd2;
        end
        default: idx_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/frame_loader.sv
// frame_loader: packs an RGB888 byte stream into pixels and writes them
// row-major into the back bank of a double-buffered frame store. Banks swap
// only on a display frame_end after the full frame has been written.
//   clk, rst     : clock, synchronous active-high reset
//   stream       : byte stream (frame_loader_if.slave)
//   frame_end    : 1-cycle pulse, display finished its last row
//   wr_en        : frame store write strobe
//   wr_addr      : write address {row, col}
//   wr_data      : packed pixel {R, G, B}
//   wr_bank      : bank being written, always ~disp_bank
//   disp_bank    : bank the display reads
//   frame_loaded : 1-cycle pulse after a bank swap
//   sof_err      : 1-cycle pulse, in_sof arrived mid-frame
//
// state     | meaning
// WAIT_SOF  | drop bytes until one carries in_sof
// LOAD      | packing and writing pixels of the current frame
// SWAP_PEND | frame complete, stall input until display frame_end
module frame_loader
  import hub75_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  frame_loader_if.slave     stream,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              frame_loaded,
  output logic              sof_err
);

  fl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt;
  logic              fire;
  logic              pk_accept, pk_restart, sof_bad, swap;
  logic [1:0]        byte_idx;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix;

  assign stream.in_ready = !rst && (state_q != SWAP_PEND);
  assign fire            = stream.in_valid && stream.in_ready;
  assign wr_bank         = ~disp_bank;

  rgb_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (pk_accept),
    .restart   (pk_restart),
    .data      (stream.in_data),
    .byte_idx  (byte_idx),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SOF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pk_accept  = 1'b0;
    pk_restart = 1'b0;
    sof_bad    = 1'b0;
    swap       = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (fire && stream.in_sof) begin
          pk_accept  = 1'b1;
          pk_restart = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          pk_accept = 1'b1;
          if (stream.in_sof) begin
            // sof is only legal at the very first byte of the frame
            pk_restart = 1'b1;
            sof_bad    = (byte_idx != 2'd0) || (pix_cnt != '0);
          end else if ((byte_idx == 2'd2) && (pix_cnt == LAST_ADDR)) begin
            state_d = SWAP_PEND;
          end
        end
      end
      SWAP_PEND: begin
        // a frame_end coinciding with the final write is not honoured
        if (frame_end && !wr_en) begin
          swap    = 1'b1;
          state_d = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      pix_cnt      <= '0;
      disp_bank    <= 1'b0;
      frame_loaded <= 1'b0;
      sof_err      <= 1'b0;
    end else begin
      wr_en        <= pix_valid;
      sof_err      <= sof_bad;
      frame_loaded <= swap;
      if (pix_valid) begin
        wr_addr <= pix_cnt;
        wr_data <= pix;
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (pk_restart) pix_cnt <= '0;
      if (swap) begin
        disp_bank <= ~disp_bank;
        pix_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;
  import hub75_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_end = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_bank;
  logic              disp_bank;
  logic              frame_loaded;
  logic              sof_err;

  frame_loader_if s_if ();

  frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .stream       (s_if.slave),
    .frame_end    (frame_end),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_bank      (wr_bank),
    .disp_bank    (disp_bank),
    .frame_loaded (frame_loaded),
    .sof_err      (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
    logic              bank;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_fl  = 0;
  int n_se  = 0;

  // scoreboard monitor: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (frame_loaded === 1'b1) n_fl++;
    if (sof_err === 1'b1) n_se++;
    if (wr_en === 1'b1) begin
      n_wr++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual addr=%0h data=%0h bank=%0b expected no write",
                 wr_addr, wr_data, wr_bank);
      end else begin
        e = q.pop_front();
        if ({wr_addr, wr_data, wr_bank} !== e) begin
          bad++;
          $display("FAIL wr_cmp actual addr=%0h data=%0h bank=%0b expected addr=%0h data=%0h bank=%0b",
                   wr_addr, wr_data, wr_bank, e.addr, e.data, e.bank);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    int n = 0;
    while (s_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (s_if.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual in_ready=%0b expected 1 within 50 cycles", s_if.in_ready);
    end
    s_if.in_valid = 1'b1;
    s_if.in_data  = d;
    s_if.in_sof   = sof;
    @(posedge clk);
    #1;
    s_if.in_valid = 1'b0;
    s_if.in_sof   = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] px, input logic sof,
                            input logic [ADDR_W-1:0] addr, input logic bank);
    q.push_back({addr, px, bank});
    send_byte(px[23:16], sof);
    send_byte(px[15:8], 1'b0);
    send_byte(px[7:0], 1'b0);
  endtask

  task automatic pulse_fe;
    frame_end = 1'b1;
    @(posedge clk);
    #1;
    frame_end = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(s_if.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    s_if.in_valid = 1'b0;
    s_if.in_data  = 8'h00;
    s_if.in_sof   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  32'(s_if.in_ready), 0);
    check("reset_wr_en",     32'(wr_en), 0);
    check("reset_wr_addr",   32'(wr_addr), 0);
    check("reset_wr_data",   32'(wr_data), 0);
    check("reset_disp_bank", 32'(disp_bank), 0);
    check("reset_wr_bank",   32'(wr_bank), 1);
    check("reset_loaded",    32'(frame_loaded), 0);
    check("reset_sof_err",   32'(sof_err), 0);
    rst = 1'b0;
    idle(1);
    check("post_reset_ready", 32'(s_if.in_ready), 1);

    // bytes without sof are dropped; frame_end in WAIT_SOF is ignored
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    pulse_fe;
    idle(3);
    check("nosof_writes", 32'(n_wr), 0);
    check("nosof_ready", 32'(s_if.in_ready), 1);
    check("nosof_disp", 32'(disp_bank), 0);

    // first pixel
    send_pixel(24'h112233, 1'b1, 12'h000, 1'b1);
    check("px0_wr_en_now", 32'(wr_en), 1);
    idle(2);
    check("px0_writes", 32'(n_wr), 1);

    // pixels 1..4, then sof on the G byte of pixel 5
    for (int i = 1; i < 5; i++)
      send_pixel(24'(i * 24'h010203), 1'b0, 12'(i), 1'b1);
    send_byte(8'h55, 1'b0);
    q.push_back({12'h000, 24'hAABBCC, 1'b1});
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    idle(2);
    check("sof_err_count", 32'(n_se), 1);
    check("sof_err_low", 32'(sof_err), 0);
    check("sof_writes", 32'(n_wr), 6);
    do_reset;

    // full frame, data = addr, written to bank 1
    for (int a = 0; a < PANEL_COLS * PANEL_ROWS; a++) begin
      send_pixel(24'(a), a == 0, 12'(a), 1'b1);
      if (a % 1000 == 7) idle(2);
    end
    check("full_ready_low0", 32'(s_if.in_ready), 0);
    idle(5);
    check("full_ready_low5", 32'(s_if.in_ready), 0);
    check("full_disp_before", 32'(disp_bank), 0);
    check("full_queue_empty", 32'(q.size()), 0);
    pulse_fe;
    check("full_disp_after", 32'(disp_bank), 1);
    check("full_wrbank_after", 32'(wr_bank), 0);
    check("full_loaded", 32'(frame_loaded), 1);
    check("full_ready_after", 32'(s_if.in_ready), 1);
    idle(2);
    check("full_loaded_count", 32'(n_fl), 1);
    check("full_writes", 32'(n_wr), 6 + 4096);

    // 100 pixels into bank 0 plus a partial pixel, then reset mid-frame
    base = n_wr;
    for (int a = 0; a < 100; a++)
      send_pixel(24'h00A000 | 24'(a), a == 0, 12'(a), 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    idle(2);
    do_reset;
    check("rst_mid_disp", 32'(disp_bank), 0);
    check("rst_mid_wrbank", 32'(wr_bank), 1);
    idle(4);
    check("rst_mid_wr_en", 32'(wr_en), 0);
    check("rst_mid_writes", 32'(n_wr - base), 100);

    // fresh frame from addr 0; frame_end mid-frame and coincident with final write
    for (int a = 0; a < PANEL_COLS * PANEL_ROWS; a++) begin
      send_pixel({a[7:0], 4'h5, a[11:0]}, a == 0, 12'(a), 1'b1);
      if (a == 2000) pulse_fe;
    end
    check("coinc_wr_en", 32'(wr_en), 1);
    pulse_fe;
    check("coinc_disp", 32'(disp_bank), 0);
    check("coinc_loaded", 32'(frame_loaded), 0);
    idle(3);
    check("coinc_ready", 32'(s_if.in_ready), 0);
    pulse_fe;
    check("second_fe_disp", 32'(disp_bank), 1);
    check("second_fe_wrbank", 32'(wr_bank), 0);
    check("second_fe_loaded", 32'(frame_loaded), 1);
    idle(2);
    check("final_loaded_count", 32'(n_fl), 2);
    check("final_queue_empty", 32'(q.size()), 0);
    check("final_writes", 32'(n_wr - base), 100 + 4096);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
